// File: rtl/qr_wavefront_seq_if.sv
// Handshake and feed bundle between the sample source, the QR wavefront
// sequencer and the systolic array top row.
interface qr_wavefront_seq_if #(
  parameter int WIDTH = 32,
  parameter int COLS  = 4,
  parameter int ROWS  = 2
);
  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic [COLS*WIDTH-1:0]   in_data;
  logic [COLS*WIDTH-1:0]   x_skew;
  logic [COLS-1:0]         x_skew_vld;
  logic [ROWS*COLS-1:0]    op;
  logic                    busy;
  logic                    done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, x_skew, x_skew_vld, op, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, x_skew, x_skew_vld, op, busy, done
  );
endinterface

// File: rtl/qr_wavefront_seq.sv
// Feed/control sequencer for a ROWS x COLS Givens-rotation QR systolic array.
// Optional feature macro: QR_CONT_EN (back-to-back blocks without draining).
module qr_wavefront_seq #(
  parameter int WIDTH    = 32,
  parameter int COLS     = 4,
  parameter int ROWS     = 2,
  parameter int NVEC     = 8,
  parameter int CELL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  qr_wavefront_seq_if.slave     bus,
  output logic [1:0]            state_dbg
);

  // Token delay line length: hops from cell (0,0) to cell (ROWS-1,COLS-1).
  localparam int DEPTH = (ROWS + COLS - 2) * CELL_LAT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic [7:0]           vec_cnt;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [DEPTH:0]       first_tok;
  logic [DEPTH:0]       last_tok;
  logic                 acc;
  logic                 is_first;
  logic                 is_last;
  logic [ROWS*COLS-1:0] op_vec;
  wire  [COLS*WIDTH-1:0] x_skew_w;
  wire  [COLS-1:0]       x_vld_w;

  // Handshake: a vector transfers on every edge where in_valid && in_ready;
  // in_ready is high exactly while in FEED and never depends on in_valid.
  assign acc      = bus.in_valid & in_ready_q;
  assign is_first = acc && (vec_cnt == 8'd0);
  assign is_last  = acc && (vec_cnt == 8'(NVEC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vec_cnt    <= 8'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      first_tok  <= '0;
      last_tok   <= '0;
    end else begin
      first_tok <= {first_tok[DEPTH-1:0], is_first};
      last_tok  <= {last_tok[DEPTH-1:0], is_last};
      done_q    <= last_tok[DEPTH];
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_FEED;
            vec_cnt    <= 8'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_FEED: begin
          if (acc) begin
            if (is_last) begin
`ifdef QR_CONT_EN
              if (bus.start) begin
                vec_cnt <= 8'd0;
              end else begin
                state      <= S_DRAIN;
                in_ready_q <= 1'b0;
              end
`else
              state      <= S_DRAIN;
              in_ready_q <= 1'b0;
`endif
            end else begin
              vec_cnt <= vec_cnt + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          // Earlier chained blocks may report done while a later one is still in flight.
          if (done_q && (last_tok == '0)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    op_vec = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if (j >= i) begin
          op_vec[i*COLS + j] = first_tok[(i + j) * CELL_LAT];
        end
      end
    end
  end

  // Column j is delayed j*CELL_LAT stages ahead of its output register;
  // empty slots carry zero data so a bubble looks like a zero row to the array.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic [WIDTH-1:0] entry;
    logic [WIDTH-1:0] out_d;
    logic             out_v;

    assign entry = acc ? bus.in_data[j*WIDTH +: WIDTH] : '0;

    if (j == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (rst) begin
          out_d <= '0;
          out_v <= 1'b0;
        end else begin
          out_d <= entry;
          out_v <= acc;
        end
      end
    end else begin : g_delay
      localparam int DEP = j * CELL_LAT;
      logic [WIDTH-1:0] cd [DEP];
      logic [DEP-1:0]   cv;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEP; k++) begin
            cd[k] <= '0;
          end
          cv    <= '0;
          out_d <= '0;
          out_v <= 1'b0;
        end else begin
          cd[0] <= entry;
          cv[0] <= acc;
          for (int k = 1; k < DEP; k++) begin
            cd[k] <= cd[k-1];
            cv[k] <= cv[k-1];
          end
          out_d <= cd[DEP-1];
          out_v <= cv[DEP-1];
        end
      end
    end

    assign x_skew_w[j*WIDTH +: WIDTH] = out_d;
    assign x_vld_w[j]                 = out_v;
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.op         = op_vec;
  assign bus.x_skew     = x_skew_w;
  assign bus.x_skew_vld = x_vld_w;
  assign state_dbg      = state;

endmodule
